// File: rtl/prbs7_lock_monitor.sv
// PRBS7 lock monitor: declares lock after a run of good checker words, drops it
// after a run of bad words, and counts (saturating) error words seen while locked.
`timescale 1ns/1ps
module prbs7_lock_monitor #(
    parameter int LOCK_COUNT   = 31,
    parameter int UNLOCK_COUNT = 4,
    parameter int ERRCNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    // enable acts as a per-word valid with no back-pressure: error is only
    // meaningful, and state only moves, on cycles where enable is high.
    input  logic                    enable,
    input  logic                    error,
    input  logic                    clear_count,
    output logic                    locked,
    output logic                    lock_lost,
    output logic [ERRCNT_WIDTH-1:0] err_count,
    output logic                    err_count_sat,
    output logic                    dbg_state
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0]              LOCK_LIM   = LOCK_COUNT[7:0];
    localparam logic [7:0]              UNLOCK_LIM = UNLOCK_COUNT[7:0];
    localparam logic [ERRCNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [ERRCNT_WIDTH-1:0] CNT_ONE    = ERRCNT_WIDTH'(1);

    state_t                  state, state_nxt;
    logic [7:0]              good_run, good_nxt;
    logic [7:0]              bad_run, bad_nxt;
    logic                    lost_nxt;
    logic [ERRCNT_WIDTH-1:0] cnt_nxt;
    logic                    sat_nxt;

    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        good_nxt  = good_run;
        bad_nxt   = bad_run;
        lost_nxt  = 1'b0;
        cnt_nxt   = err_count;
        sat_nxt   = err_count_sat;
        if (enable) begin
            case (state)
                SEARCH: begin
                    if (error) begin
                        good_nxt = 8'd0;
                    end else if (good_run + 8'd1 == LOCK_LIM) begin
                        state_nxt = LOCKED;
                        good_nxt  = 8'd0;
                    end else begin
                        good_nxt = good_run + 8'd1;
                    end
                end
                LOCKED: begin
                    if (error) begin
                        if (err_count != CNT_MAX) begin
                            cnt_nxt = err_count + CNT_ONE;
                        end
                        sat_nxt = err_count_sat | (cnt_nxt == CNT_MAX);
                        if (bad_run + 8'd1 == UNLOCK_LIM) begin
                            state_nxt = SEARCH;
                            bad_nxt   = 8'd0;
                            lost_nxt  = 1'b1;
                        end else begin
                            bad_nxt = bad_run + 8'd1;
                        end
                    end else begin
                        bad_nxt = 8'd0;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
        // A clear in the same cycle as an increment leaves the counter at zero.
        if (clear_count) begin
            cnt_nxt = '0;
            sat_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SEARCH;
            good_run      <= 8'd0;
            bad_run       <= 8'd0;
            locked        <= 1'b0;
            lock_lost     <= 1'b0;
            err_count     <= '0;
            err_count_sat <= 1'b0;
        end else begin
            state         <= state_nxt;
            good_run      <= good_nxt;
            bad_run       <= bad_nxt;
            locked        <= (state_nxt == LOCKED);
            lock_lost     <= lost_nxt;
            err_count     <= cnt_nxt;
            err_count_sat <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_prbs7_lock_monitor.sv
// Bench for prbs7_lock_monitor: three parameterisations share one stimulus stream
// and are checked every cycle against an arithmetic model, plus directed checks.
`timescale 1ns/1ps
module tb_prbs7_lock_monitor;

    typedef struct {
        int good;
        int bad;
        bit lk;
        int errc;
        bit sat;
        bit lost;
    } mdl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic error = 1'b0;
    logic clear_count = 1'b0;

    logic        la, lla, sa, da;
    logic [15:0] eca;
    logic        lb, llb, sb, db;
    logic [3:0]  ecb;
    logic        lc, llc, sc, dc;
    logic [7:0]  ecc;

    int   total = 0;
    int   bad = 0;
    mdl_t m[3];
    int   lc_p[3] = '{31, 1, 1};
    int   uc_p[3] = '{4, 255, 1};
    int   mx_p[3] = '{65535, 15, 255};
    logic [18:0] exp_q[$];
    int   pulses;

    // clock / reset
    always #12.5 clk = ~clk;

    prbs7_lock_monitor dut_a (
        .clk(clk), .reset(reset), .enable(enable), .error(error), .clear_count(clear_count),
        .locked(la), .lock_lost(lla), .err_count(eca), .err_count_sat(sa), .dbg_state(da));

    prbs7_lock_monitor #(.LOCK_COUNT(1), .UNLOCK_COUNT(255), .ERRCNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .error(error), .clear_count(clear_count),
        .locked(lb), .lock_lost(llb), .err_count(ecb), .err_count_sat(sb), .dbg_state(db));

    prbs7_lock_monitor #(.LOCK_COUNT(1), .UNLOCK_COUNT(1), .ERRCNT_WIDTH(8)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .error(error), .clear_count(clear_count),
        .locked(lc), .lock_lost(llc), .err_count(ecc), .err_count_sat(sc), .dbg_state(dc));

    function automatic mdl_t step_m(mdl_t s, int lcnt, int ucnt, int mx,
                                    bit en, bit er, bit clr, bit rst);
        mdl_t n = s;
        n.lost = 1'b0;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        if (en && !s.lk) begin
            if (er) n.good = 0;
            else if (s.good + 1 == lcnt) begin
                n.lk   = 1'b1;
                n.good = 0;
            end else n.good = s.good + 1;
        end else if (en && s.lk) begin
            if (er) begin
                if (n.errc < mx) n.errc = n.errc + 1;
                if (n.errc == mx) n.sat = 1'b1;
                n.bad = s.bad + 1;
                if (n.bad == ucnt) begin
                    n.lk   = 1'b0;
                    n.bad  = 0;
                    n.lost = 1'b1;
                end
            end else n.bad = 0;
        end
        if (clr) begin
            n.errc = 0;
            n.sat  = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: dut_a via expected queue, dut_b/dut_c field by field
    task automatic check_all();
        logic [18:0] e;
        e = exp_q.pop_front();
        chk("a_outputs", {13'd0, la, lla, sa, eca}, {13'd0, e});
        chk("a_state", {31'd0, da}, {31'd0, m[0].lk});
        chk("b_locked", {31'd0, lb}, {31'd0, m[1].lk});
        chk("b_lost", {31'd0, llb}, {31'd0, m[1].lost});
        chk("b_count", {28'd0, ecb}, 32'(m[1].errc));
        chk("b_sat", {31'd0, sb}, {31'd0, m[1].sat});
        chk("c_locked", {31'd0, lc}, {31'd0, m[2].lk});
        chk("c_lost", {31'd0, llc}, {31'd0, m[2].lost});
        chk("c_count", {24'd0, ecc}, 32'(m[2].errc));
        chk("c_sat", {31'd0, sc}, {31'd0, m[2].sat});
        chk("c_state", {31'd0, dc}, {31'd0, m[2].lk});
    endtask

    // driver: one clock cycle of stimulus, model update, check after the edge
    task automatic cyc(input bit en, input bit er, input bit clr, input bit rst);
        enable      = en;
        error       = er;
        clear_count = clr;
        reset       = rst;
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = step_m(m[i], lc_p[i], uc_p[i], mx_p[i], en, er, clr, rst);
        exp_q.push_back({m[0].lk, m[0].lost, m[0].sat, m[0].errc[15:0]});
        #1;
        check_all();
    endtask

    task automatic words(input int n, input bit er);
        for (int i = 0; i < n; i++) cyc(1'b1, er, 1'b0, 1'b0);
    endtask

    initial begin
        int mode;
        int rate;
        for (int i = 0; i < 3; i++) m[i] = '{default: 0};
        #1;

        // reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_locked", {31'd0, la}, 32'd0);
        chk("rst_count", {16'd0, eca}, 32'd0);

        // lock after exactly 31 good words; first-word error only holds SEARCH
        words(1, 1'b1);
        chk("first_err_uncounted", {16'd0, eca}, 32'd0);
        words(30, 1'b0);
        chk("lock_after_30", {31'd0, la}, 32'd0);
        words(1, 1'b0);
        chk("lock_after_31", {31'd0, la}, 32'd1);
        chk("lock_count", {16'd0, eca}, 32'd0);

        // E E E G E E E E while locked
        words(3, 1'b1);
        words(1, 1'b0);
        words(3, 1'b1);
        chk("still_locked", {31'd0, la}, 32'd1);
        chk("no_pulse_yet", {31'd0, lla}, 32'd0);
        words(1, 1'b1);
        chk("unlock_pulse", {31'd0, lla}, 32'd1);
        chk("unlock_locked", {31'd0, la}, 32'd0);
        chk("unlock_count", {16'd0, eca}, 32'd7);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pulse_one_cycle", {31'd0, lla}, 32'd0);
        chk("stays_search", {31'd0, la}, 32'd0);

        // clear does not disturb lock state; then 20 good, error, 31 good
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clear_count", {16'd0, eca}, 32'd0);
        words(20, 1'b0);
        words(1, 1'b1);
        words(30, 1'b0);
        chk("relock_30", {31'd0, la}, 32'd0);
        words(1, 1'b0);
        chk("relock_31", {31'd0, la}, 32'd1);
        chk("relock_count", {16'd0, eca}, 32'd0);

        // bad run spans idle cycles
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            pulses += int'(lla);
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            pulses += int'(lla);
        end
        chk("gap_unlock", {31'd0, la}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        pulses += int'(lla);
        chk("gap_pulses", 32'(pulses), 32'd1);

        // narrow counter saturation and clear-wins on dut_b
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        words(20, 1'b1);
        chk("b_sat_count", {28'd0, ecb}, 32'd15);
        chk("b_sat_flag", {31'd0, sb}, 32'd1);
        chk("b_sat_locked", {31'd0, lb}, 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("b_clear_wins_cnt", {28'd0, ecb}, 32'd0);
        chk("b_clear_wins_sat", {31'd0, sb}, 32'd0);

        // LOCK_COUNT=1 / UNLOCK_COUNT=1 on dut_c
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        words(1, 1'b0);
        chk("c_lock_first", {31'd0, lc}, 32'd1);
        words(1, 1'b1);
        chk("c_unlock_first", {31'd0, lc}, 32'd0);
        chk("c_unlock_pulse", {31'd0, llc}, 32'd1);

        // reset while locked with err_count=9
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        words(31, 1'b0);
        for (int i = 0; i < 3; i++) begin
            words(3, 1'b1);
            words(1, 1'b0);
        end
        chk("pre_rst_count", {16'd0, eca}, 32'd9);
        chk("pre_rst_locked", {31'd0, la}, 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("mid_rst_locked", {31'd0, la}, 32'd0);
        chk("mid_rst_count", {16'd0, eca}, 32'd0);
        chk("mid_rst_lost", {31'd0, lla}, 32'd0);

        // randomized traffic with bursty error rate
        mode = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 80 == 0) mode = $urandom_range(0, 2);
            rate = (mode == 0) ? 1 : (mode == 1) ? 40 : 90;
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 99) < rate,
                $urandom_range(0, 199) == 0,
                $urandom_range(0, 999) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
